mode_sequencer: RTL



---
 rtl/mode_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// mode_sequencer: two-button mode controller with synchroniser, debounce,
// auto-repeat and wrap-around next/previous stepping of the calculator mode.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   key_n[1:0]   raw active-low buttons; [0] = next, [1] = previous
//   mode         current mode, 0..NUM_MODES-1, registered
//   mode_changed one-cycle pulse in the cycle mode holds its new value
//   pressed[1:0] debounced accepted key levels (1 = pressed), registered
module mode_sequencer #(
    parameter int NUM_MODES       = 12,
    parameter int MODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        key_n,
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed,
    output logic [1:0]        pressed
);

    localparam bit REP_EN = (REPEAT_DELAY != 0);
    localparam int RD     = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
    localparam int RP     = (REPEAT_PERIOD < 1) ? 1 : REPEAT_PERIOD;
    localparam int RMAX   = (RD > RP) ? RD : RP;
    localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW     = $clog2(RMAX + 1);

    localparam logic [DW-1:0]     DB_LIM   = DW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0]     RD_LAST  = RW'(RD - 1);
    localparam logic [RW-1:0]     RP_LAST  = RW'(RP - 1);
    localparam logic [MODE_W-1:0] MODE_TOP = MODE_W'(NUM_MODES - 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [DW-1:0] db_cnt [2];
    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    rep_first;
    logic [1:0]    rep_armed;

    logic [1:0]    flip;
    logic [1:0]    press_evt;
    logic [1:0]    rep_evt;
    logic          inc;
    logic          dec;

    assign level = ~sync2;

    always_comb begin
        flip      = '0;
        press_evt = '0;
        rep_evt   = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i]      = (db_cnt[i] == DB_LIM);
            press_evt[i] = flip[i] && !pressed[i];
            // Repeat only while the raw synchronised key is still held, so
            // a released key never produces a late step during debounce.
            rep_evt[i]   = REP_EN && rep_armed[i] && pressed[i] && level[i]
                           && (rep_cnt[i] == (rep_first[i] ? RD_LAST
                                                           : RP_LAST));
        end
    end

    assign inc = press_evt[0] | rep_evt[0];
    assign dec = press_evt[1] | rep_evt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= 2'b11;
            sync2        <= 2'b11;
            pressed      <= 2'b00;
            rep_first    <= 2'b00;
            rep_armed    <= 2'b00;
            mode         <= '0;
            mode_changed <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i]  <= '0;
                rep_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;

            for (int i = 0; i < 2; i++) begin
                if (flip[i]) begin
                    pressed[i] <= ~pressed[i];
                    db_cnt[i]  <= '0;
                end else if (level[i] != pressed[i]) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db_cnt[i] <= '0;
                end

                if (press_evt[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                    rep_armed[i] <= REP_EN;
                end else if (!rep_armed[i] || !pressed[i] || !level[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                    rep_armed[i] <= 1'b0;
                end else if (rep_evt[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end

            // Coincident next/previous events cancel.
            unique case (1'b1)
                inc && !dec: begin
                    mode         <= (mode == MODE_TOP) ? '0 : mode + 1'b1;
                    mode_changed <= 1'b1;
                end
                dec && !inc: begin
                    mode         <= (mode == '0) ? MODE_TOP : mode - 1'b1;
                    mode_changed <= 1'b1;
                end
                default: begin
                    mode_changed <= 1'b0;
                end
            endcase
        end
    end

endmodule
